// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// byte-strobe patterns and the request legality check.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE    = 4'b0001;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Unknown funct3 or an access that straddles its natural alignment.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (f3)
                SB:      bad = 1'b0;
                SH:      bad = addr_lo[0];
                SW:      bad = (addr_lo != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                LB, LBU: bad = 1'b0;
                LH, LHU: bad = addr_lo[0];
                LW:      bad = (addr_lo != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_mem_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output valid, we, addr, wdata, wstrb, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and strobes, load byte/half
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = 8'(rdata >> {addr_lo, 3'b000});
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      rdata_ext = {{24{rbyte[7]}}, rbyte};
            LBU:     rdata_ext = {24'b0, rbyte};
            LH:      rdata_ext = {{16{rhalf[15]}}, rhalf};
            LHU:     rdata_ext = {16'b0, rhalf};
            default: rdata_ext = rdata;
        endcase

        case (funct3)
            SB: begin
                wdata_rep = {4{wdata[7:0]}};
                wstrb     = STRB_BYTE << addr_lo;
            end
            SH: begin
                wdata_rep = {2{wdata[15:0]}};
                wstrb     = addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
            end
            default: begin
                wdata_rep = wdata;
                wstrb     = STRB_WORD;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// state | meaning
// IDLE  | waiting for req_valid; illegal requests go straight to DONE
// REQ   | mem_valid asserted until mem_ready
// WAIT  | load accepted, waiting for mem_rvalid
// DONE  | one-cycle response (rsp_valid)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   input  logic         req_we,
   input  logic [2:0]   req_funct3,
   input  logic [31:0]  req_addr,
   input  logic [31:0]  req_wdata,
   output logic         stall,
   output logic         rsp_valid,
   output logic [31:0]  rsp_rdata,
   output logic         fault,
   output logic         mem_valid,
   input  logic         mem_ready,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   output logic [3:0]   mem_wstrb,
   input  logic         mem_rvalid,
   input  logic [31:0]  mem_rdata
);

   lsu_state_t  state, state_nx;
   logic        l_we;
   logic [2:0]  l_funct3;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        fault_nx;
   logic [31:0] rdata_nx;
   logic [31:0] wdata_rep;
   logic [3:0]  strb;
   logic [31:0] rdata_ext;
   logic        timeout_hit;

   lsu_align u_align (
      .funct3    (l_funct3),
      .addr_lo   (l_addr[1:0]),
      .wdata     (l_wdata),
      .rdata     (mem_rdata),
      .wdata_rep (wdata_rep),
      .wstrb     (strb),
      .rdata_ext (rdata_ext)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         to_cnt <= '0;
      else if (state == REQ || state == WAIT)
         to_cnt <= to_cnt + 1'b1;
      else
         to_cnt <= '0;
   end

   assign timeout_hit = (state == REQ || state == WAIT) &&
                        (to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_we      <= 1'b0;
         l_funct3  <= 3'b000;
         l_addr    <= '0;
         l_wdata   <= '0;
         rsp_rdata <= '0;
         fault     <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            l_we     <= req_we;
            l_funct3 <= req_funct3;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
         end
         rsp_rdata <= (state_nx == DONE) ? rdata_nx : '0;
         fault     <= (state_nx == DONE) && fault_nx;
      end
   end

   always_comb begin
      state_nx = state;
      fault_nx = 1'b0;
      rdata_nx = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
                  state_nx = DONE;
                  fault_nx = 1'b1;
               end else begin
                  state_nx = REQ;
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               if (l_we) begin
                  state_nx = DONE;
               end else if (mem_rvalid) begin
                  state_nx = DONE;
                  rdata_nx = rdata_ext;
               end else begin
                  state_nx = WAIT;
               end
            end else if (timeout_hit) begin
               state_nx = DONE;
               fault_nx = 1'b1;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_nx = DONE;
               rdata_nx = rdata_ext;
            end else if (timeout_hit) begin
               state_nx = DONE;
               fault_nx = 1'b1;
            end
         end
         DONE: state_nx = IDLE;
      endcase
   end

   always_comb begin
      stall     = 1'b0;
      rsp_valid = 1'b0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = STRB_NONE;
      case (state)
         IDLE: stall = req_valid;
         REQ: begin
            stall     = 1'b1;
            mem_valid = 1'b1;
            mem_we    = l_we;
            mem_addr  = {l_addr[31:2], 2'b00};
            if (l_we) begin
               mem_wdata = wdata_rep;
               mem_wstrb = strb;
            end
         end
         WAIT: stall = 1'b1;
         DONE: rsp_valid = 1'b1;
      endcase
   end

endmodule
